// File: rtl/exec_pkg.sv
// Shared encodings and the ROB age helper for the superscalar execute stage.
package exec_pkg;

  typedef enum logic [2:0] {
    BR_NONE = 3'd0,
    BR_BEQ  = 3'd1,
    BR_BNE  = 3'd2,
    BR_BLT  = 3'd3,
    BR_BGE  = 3'd4,
    BR_BLTU = 3'd5,
    BR_JAL  = 3'd6,
    BR_JALR = 3'd7
  } branch_sel_e;

  typedef enum logic [3:0] {
    FN_ADD   = 4'd0,
    FN_SUB   = 4'd1,
    FN_AND   = 4'd2,
    FN_OR    = 4'd3,
    FN_XOR   = 4'd4,
    FN_SLL   = 4'd5,
    FN_SRL   = 4'd6,
    FN_SRA   = 4'd7,
    FN_SLT   = 4'd8,
    FN_SLTU  = 4'd9,
    FN_PASSB = 4'd10
  } func_sel_e;

  // True when tag_a is strictly older than tag_b relative to head, modulo 2^tag_w (tag_w 1..31).
  function automatic logic age_lt(input logic [31:0] tag_a, input logic [31:0] tag_b,
                                  input logic [31:0] head, input int tag_w);
    logic [31:0] mask;
    mask = (32'd1 << tag_w) - 32'd1;
    return ((tag_a - head) & mask) < ((tag_b - head) & mask);
  endfunction

endpackage

// File: rtl/superscalar_execute_stage_pipelined_lane.sv
// One execute lane: ALU/shifter, branch resolution, and the CDB output register with handshake.
module exec_lane
  import exec_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int TAG_W      = 5
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          flush,
  input  logic                          iss_valid,
  output logic                          iss_ready,
  input  logic signed [DATA_WIDTH-1:0]  data_a,
  input  logic signed [DATA_WIDTH-1:0]  data_b,
  input  logic [3:0]                    func_sel,
  input  logic                          save_pc,
  input  logic                          mem_addr,
  input  logic [2:0]                    branch_sel,
  input  logic                          pred_taken,
  input  logic [DATA_WIDTH-1:0]         pred_pc,
  input  logic [DATA_WIDTH-1:0]         alt_pc,
  input  logic [TAG_W-1:0]              tag,
  input  logic                          cdb_ready,
  output logic                          cdb_valid,
  output logic [DATA_WIDTH-1:0]         cdb_result,
  output logic [TAG_W-1:0]              cdb_tag,
  output logic                          cdb_mispredict,
  output logic [DATA_WIDTH-1:0]         cdb_correct_pc,
  output logic                          cdb_mem_addr,
  output logic                          cap,
  output logic                          cap_mispredict,
  output logic                          cap_cond,
  output logic                          cap_taken,
  output logic [DATA_WIDTH-1:0]         cap_correct_pc
);

  localparam int SHW = $clog2(DATA_WIDTH);

  function automatic logic signed [DATA_WIDTH-1:0] alu_op(input func_sel_e fn,
                                                          input logic signed [DATA_WIDTH-1:0] a,
                                                          input logic signed [DATA_WIDTH-1:0] b);
    logic [SHW-1:0] sh;
    sh = b[SHW-1:0];
    case (fn)
      FN_ADD:   return a + b;
      FN_SUB:   return a - b;
      FN_AND:   return a & b;
      FN_OR:    return a | b;
      FN_XOR:   return a ^ b;
      FN_SLL:   return a << sh;
      FN_SRL:   return $signed($unsigned(a) >> sh);
      FN_SRA:   return a >>> sh;
      FN_SLT:   return (a < b) ? DATA_WIDTH'(1) : '0;
      FN_SLTU:  return ($unsigned(a) < $unsigned(b)) ? DATA_WIDTH'(1) : '0;
      FN_PASSB: return b;
      default:  return '0;
    endcase
  endfunction

  function automatic logic br_cond(input branch_sel_e sel,
                                   input logic signed [DATA_WIDTH-1:0] a,
                                   input logic signed [DATA_WIDTH-1:0] b);
    case (sel)
      BR_BEQ:  return a == b;
      BR_BNE:  return a != b;
      BR_BLT:  return a < b;
      BR_BGE:  return a >= b;
      BR_BLTU: return $unsigned(a) < $unsigned(b);
      default: return 1'b0;
    endcase
  endfunction

  branch_sel_e                  br_e;
  logic signed [DATA_WIDTH-1:0] alu_res;
  logic [DATA_WIDTH-1:0]        link_pc, jalr_tgt, result_c, cpc_c;
  logic                         is_cond, taken_c, misp_c;

  logic                         vld_p1;
  logic [DATA_WIDTH-1:0]        result_p1, cpc_p1;
  logic [TAG_W-1:0]             tag_p1;
  logic                         misp_p1, mem_p1;

  // Stage 0: combinational execute and branch resolution
  always_comb begin
    br_e     = branch_sel_e'(branch_sel);
    alu_res  = alu_op(func_sel_e'(func_sel), data_a, data_b);
    link_pc  = {alt_pc[DATA_WIDTH-1:2], 2'b00};
    jalr_tgt = {alu_res[DATA_WIDTH-1:2], 2'b00};
    is_cond  = (branch_sel >= 3'd1) && (branch_sel <= 3'd5);
    taken_c  = br_cond(br_e, data_a, data_b);
    result_c = save_pc ? link_pc : alu_res;
    cpc_c    = link_pc;
    misp_c   = 1'b0;
    if (is_cond) begin
      result_c = pred_pc;
      misp_c   = taken_c ^ pred_taken;
    end else if (br_e == BR_JALR) begin
      cpc_c  = jalr_tgt;
      misp_c = (jalr_tgt != pred_pc);
    end
  end

  // Flush keeps the lane open so upstream never sees backpressure while draining the pipe.
  assign iss_ready      = !vld_p1 || cdb_ready || flush;
  assign cap            = iss_valid && iss_ready && !flush;
  assign cap_mispredict = misp_c;
  assign cap_cond       = is_cond;
  assign cap_taken      = taken_c;
  assign cap_correct_pc = cpc_c;

  // Stage 1: CDB output register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1    <= 1'b0;
      result_p1 <= '0;
      cpc_p1    <= '0;
      tag_p1    <= '0;
      misp_p1   <= 1'b0;
      mem_p1    <= 1'b0;
    end else begin
      if (flush)          vld_p1 <= 1'b0;
      else if (iss_ready) vld_p1 <= iss_valid;
      if (cap) begin
        result_p1 <= result_c;
        cpc_p1    <= cpc_c;
        tag_p1    <= tag;
        misp_p1   <= misp_c;
        mem_p1    <= mem_addr;
      end
    end
  end

  assign cdb_valid      = vld_p1;
  assign cdb_result     = result_p1;
  assign cdb_tag        = tag_p1;
  assign cdb_mispredict = misp_p1;
  assign cdb_correct_pc = cpc_p1;
  assign cdb_mem_addr   = mem_p1;

endmodule

// File: rtl/superscalar_execute_stage_pipelined.sv
// N-lane execute stage: per-lane execute/CDB registers plus oldest-mispredict redirect and BP update pulses.
module superscalar_execute_stage_pipelined
  import exec_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_FU     = 3,
  parameter int TAG_W      = 5
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         flush,
  input  logic [TAG_W-1:0]             rob_head,
  input  logic [NUM_FU-1:0]            iss_valid,
  output logic [NUM_FU-1:0]            iss_ready,
  input  logic [NUM_FU*DATA_WIDTH-1:0] iss_data_a,
  input  logic [NUM_FU*DATA_WIDTH-1:0] iss_data_b,
  input  logic [NUM_FU*4-1:0]          iss_func_sel,
  input  logic [NUM_FU-1:0]            iss_save_pc,
  input  logic [NUM_FU-1:0]            iss_mem_addr,
  input  logic [NUM_FU*3-1:0]          iss_branch_sel,
  input  logic [NUM_FU-1:0]            iss_pred_taken,
  input  logic [NUM_FU*DATA_WIDTH-1:0] iss_pred_pc,
  input  logic [NUM_FU*DATA_WIDTH-1:0] iss_alt_pc,
  input  logic [NUM_FU*TAG_W-1:0]      iss_tag,
  output logic [NUM_FU-1:0]            cdb_valid,
  input  logic [NUM_FU-1:0]            cdb_ready,
  output logic [NUM_FU*DATA_WIDTH-1:0] cdb_result,
  output logic [NUM_FU*TAG_W-1:0]      cdb_tag,
  output logic [NUM_FU-1:0]            cdb_mispredict,
  output logic [NUM_FU*DATA_WIDTH-1:0] cdb_correct_pc,
  output logic [NUM_FU-1:0]            cdb_mem_addr,
  output logic                         redirect_valid,
  output logic [DATA_WIDTH-1:0]        redirect_pc,
  output logic [TAG_W-1:0]             redirect_tag,
  output logic [NUM_FU-1:0]            bp_update,
  output logic [NUM_FU*DATA_WIDTH-1:0] bp_update_pc,
  output logic [NUM_FU-1:0]            bp_taken
);

  localparam int DW = DATA_WIDTH;

  logic [NUM_FU-1:0]    cap, cap_misp, cap_cond, cap_taken;
  logic [NUM_FU*DW-1:0] cap_cpc;

  for (genvar g = 0; g < NUM_FU; g++) begin : g_lane
    exec_lane #(.DATA_WIDTH(DW), .TAG_W(TAG_W)) u_lane (
      .clk            (clk),
      .rst_n          (rst_n),
      .flush          (flush),
      .iss_valid      (iss_valid[g]),
      .iss_ready      (iss_ready[g]),
      .data_a         (iss_data_a[g*DW +: DW]),
      .data_b         (iss_data_b[g*DW +: DW]),
      .func_sel       (iss_func_sel[g*4 +: 4]),
      .save_pc        (iss_save_pc[g]),
      .mem_addr       (iss_mem_addr[g]),
      .branch_sel     (iss_branch_sel[g*3 +: 3]),
      .pred_taken     (iss_pred_taken[g]),
      .pred_pc        (iss_pred_pc[g*DW +: DW]),
      .alt_pc         (iss_alt_pc[g*DW +: DW]),
      .tag            (iss_tag[g*TAG_W +: TAG_W]),
      .cdb_ready      (cdb_ready[g]),
      .cdb_valid      (cdb_valid[g]),
      .cdb_result     (cdb_result[g*DW +: DW]),
      .cdb_tag        (cdb_tag[g*TAG_W +: TAG_W]),
      .cdb_mispredict (cdb_mispredict[g]),
      .cdb_correct_pc (cdb_correct_pc[g*DW +: DW]),
      .cdb_mem_addr   (cdb_mem_addr[g]),
      .cap            (cap[g]),
      .cap_mispredict (cap_misp[g]),
      .cap_cond       (cap_cond[g]),
      .cap_taken      (cap_taken[g]),
      .cap_correct_pc (cap_cpc[g*DW +: DW])
    );
  end

  logic             sel_vld;
  logic [DW-1:0]    sel_pc;
  logic [TAG_W-1:0] sel_tag;

  // Stage 0: oldest newly captured mispredict; strict compare keeps the lowest lane on equal age.
  always_comb begin
    sel_vld = 1'b0;
    sel_pc  = '0;
    sel_tag = '0;
    for (int i = 0; i < NUM_FU; i++) begin
      if (cap[i] && cap_misp[i] &&
          (!sel_vld || age_lt(32'(iss_tag[i*TAG_W +: TAG_W]), 32'(sel_tag), 32'(rob_head), TAG_W))) begin
        sel_vld = 1'b1;
        sel_pc  = cap_cpc[i*DW +: DW];
        sel_tag = iss_tag[i*TAG_W +: TAG_W];
      end
    end
  end

  logic                 redir_vld_p1;
  logic [DW-1:0]        redir_pc_p1;
  logic [TAG_W-1:0]     redir_tag_p1;
  logic [NUM_FU-1:0]    bp_vld_p1, bp_taken_p1;
  logic [NUM_FU*DW-1:0] bp_pc_p1;

  // Stage 1: redirect and predictor-update pulses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      redir_vld_p1 <= 1'b0;
      redir_pc_p1  <= '0;
      redir_tag_p1 <= '0;
      bp_vld_p1    <= '0;
      bp_taken_p1  <= '0;
      bp_pc_p1     <= '0;
    end else begin
      redir_vld_p1 <= sel_vld;
      if (sel_vld) begin
        redir_pc_p1  <= sel_pc;
        redir_tag_p1 <= sel_tag;
      end
      for (int i = 0; i < NUM_FU; i++) begin
        bp_vld_p1[i] <= cap[i] && cap_cond[i];
        if (cap[i] && cap_cond[i]) begin
          bp_taken_p1[i]         <= cap_taken[i];
          bp_pc_p1[i*DW +: DW]   <= iss_pred_pc[i*DW +: DW];
        end
      end
    end
  end

  assign redirect_valid = redir_vld_p1;
  assign redirect_pc    = redir_pc_p1;
  assign redirect_tag   = redir_tag_p1;
  assign bp_update      = bp_vld_p1;
  assign bp_update_pc   = bp_pc_p1;
  assign bp_taken       = bp_taken_p1;

endmodule
